adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the adder (2..8).
REQ-002 Parameter WIDTH, default 4: operand width; sum width WIDTH+1.
REQ-003 Parameter ADD_LAT, default 1: clock cycles from add_valid to add_c for that operation (1..4).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  NUM_REQ  per-requester request; held high with operands stable until granted.
REQ-007 req_a  input  NUM_REQ*WIDTH  operand a; slice i belongs to requester i.
REQ-008 req_b  input  NUM_REQ*WIDTH  operand b; slice i belongs to requester i.
REQ-009 gnt  output  NUM_REQ  one-hot grant, same cycle as the accepted request.
REQ-010 add_a  output  WIDTH  operand a to shared adder.
REQ-011 add_b  output  WIDTH  operand b to shared adder.
REQ-012 add_valid  output  1  operands on add_a/add_b are valid this cycle.
REQ-013 add_c  input  WIDTH+1  adder sum, valid exactly ADD_LAT cycles after its add_valid.
REQ-014 rsp_valid  output  1  result returned this cycle.
REQ-015 rsp_id  output  clog2(NUM_REQ)  requester index owning the result.
REQ-016 rsp_c  output  WIDTH+1  returned sum.
REQ-017 busy  output  1  high while any operation is in flight.

Function
REQ-018 Grant SHALL be combinational: at most one gnt bit per cycle; gnt==0 when req==0 or rst==1.
REQ-019 Arbitration SHALL be round-robin: search starts at pointer ptr, ascending index, wraps NUM_REQ-1 -> 0.
REQ-020 On grant to index i, ptr SHALL become (i+1) mod NUM_REQ at next edge; ptr unchanged when no grant.
REQ-021 add_valid SHALL equal |gnt; add_a/add_b SHALL carry the granted slice, else all zeros.
REQ-022 Each cycle a tag {valid, id} SHALL enter an ADD_LAT-deep shift register; back-to-back grants every cycle are allowed (throughput 1/cycle).
REQ-023 When the tag exiting the shift register is valid, rsp_valid SHALL be 1, rsp_id the tag id, rsp_c = add_c, all same cycle.
REQ-024 When exiting tag invalid, rsp_valid=0, rsp_id=0, rsp_c=0.
REQ-025 busy SHALL be OR of all valid bits in the tag shift register.
REQ-026 Request deasserted before grant SHALL be dropped silently; no pointer change on its account.
REQ-027 Single active requester SHALL be granted every cycle it requests regardless of ptr.
REQ-028 Results SHALL return in grant order; no reordering, no loss, no duplication.

Reset
REQ-029 When rst=1 at an edge: ptr=0, all tag valid bits=0; outputs next cycle rsp_valid=0, rsp_id=0, rsp_c=0, busy=0.
REQ-030 While rst=1: gnt=0, add_valid=0, add_a=0, add_b=0.
REQ-031 Reset mid-operation SHALL discard all in-flight tags; no rsp_valid for them after reset, even if add_c later changes.

Verification
REQ-032 Single requester: req=4'b0010, a1=3, b1=5 for one cycle -> gnt=4'b0010, add_a=3, add_b=5; ADD_LAT cycles later rsp_valid=1, rsp_id=1, rsp_c=8; busy high in between.
REQ-033 All request continuously from reset -> grant sequence 0,1,2,3,0,1 on consecutive cycles; rsp_id sequence identical, delayed ADD_LAT.
REQ-034 Pointer wrap: after grant to 3, req=4'b1001 -> grant 0 next, then 3.
REQ-035 Overflow width: a=15, b=15 (WIDTH=4) -> rsp_c=30 (5'b11110).
REQ-036 Reset mid-flight: grant req 2 with a=1,b=1, assert rst next cycle -> no rsp_valid afterwards, busy=0, next grant search starts at index 0.
REQ-037 Idle: req=0 for 10 cycles -> add_valid=0, gnt=0, rsp_valid=0, ptr unchanged.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one ADD_LAT-cycle adder; req/req_a/req_b in, gnt and add_a/add_b/add_valid to adder, add_c back, rsp_valid/rsp_id/rsp_c/busy out
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  output logic                       add_valid,
  input  logic [WIDTH:0]             add_c,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH:0]             rsp_c,
  output logic                       busy
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] ptr_q, ptr_d, gid;
  logic hit, grant;
  logic tag_v_q [ADD_LAT];
  logic tag_v_d [ADD_LAT];
  logic [IW-1:0] tag_id_q [ADD_LAT];
  logic [IW-1:0] tag_id_d [ADD_LAT];
  always_comb begin
    hit = 1'b0;
    gid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!hit && req[(int'(ptr_q) + k) % NUM_REQ]) begin
        hit = 1'b1;
        gid = IW'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end
  assign grant = hit & ~rst;
  assign gnt = grant ? NUM_REQ'(1) << gid : '0;
  assign add_valid = grant;
  assign add_a = grant ? req_a[gid*WIDTH +: WIDTH] : '0;
  assign add_b = grant ? req_b[gid*WIDTH +: WIDTH] : '0;
  assign ptr_d = grant ? (gid == IW'(NUM_REQ - 1) ? '0 : gid + 1'b1) : ptr_q;
  always_comb begin
    tag_v_d[0] = grant;
    tag_id_d[0] = gid;
    for (int i = 1; i < ADD_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < ADD_LAT; i++) tag_v_q[i] <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < ADD_LAT; i++) tag_v_q[i] <= tag_v_d[i];
    end
    for (int i = 0; i < ADD_LAT; i++) tag_id_q[i] <= tag_id_d[i];
  end
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < ADD_LAT; i++) busy = busy | tag_v_q[i];
  end
  assign rsp_valid = tag_v_q[ADD_LAT-1];
  assign rsp_id = rsp_valid ? tag_id_q[ADD_LAT-1] : '0;
  assign rsp_c = rsp_valid ? add_c : '0;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and random checks of adder_arbiter against a queue-based reference model
module tb_adder_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int L = 2;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0] gnt;
  logic [W-1:0] add_a, add_b;
  logic add_valid;
  logic [W:0] add_c;
  logic rsp_valid;
  logic [1:0] rsp_id;
  logic [W:0] rsp_c;
  logic busy;
  adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADD_LAT(L)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
    .add_c(add_c), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_c(rsp_c),
    .busy(busy)
  );
  always #5 clk = ~clk;
  logic [W:0] s_n;
  logic [W:0] pipe [L];
  always @(negedge clk) s_n = {1'b0, add_a} + {1'b0, add_b};
  always @(posedge clk) begin
    pipe[0] <= s_n;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign add_c = pipe[L-1];
  typedef struct {int due; int id; int c;} ent_t;
  ent_t q[$];
  int ptr = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [N-1:0] g_obs;
  int last_c, last_id;
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", t, o, e, cyc);
    end
  endtask
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    int g, ea, eb;
    rst = r; req = rq; req_a = a; req_b = b;
    @(negedge clk);
    g = -1;
    if (!r) for (int k = 0; k < N; k++) if (g < 0 && rq[(ptr + k) % N]) g = (ptr + k) % N;
    ea = g < 0 ? 0 : int'((a >> (g * W)) & ((1 << W) - 1));
    eb = g < 0 ? 0 : int'((b >> (g * W)) & ((1 << W) - 1));
    chk("gnt", 32'(gnt), g < 0 ? 0 : (1 << g));
    chk("add_valid", 32'(add_valid), 32'(g >= 0));
    chk("add_a", 32'(add_a), ea);
    chk("add_b", 32'(add_b), eb);
    chk("busy", 32'(busy), 32'(q.size() != 0));
    if (q.size() != 0 && q[0].due == cyc) begin
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("rsp_id", 32'(rsp_id), q[0].id);
      chk("rsp_c", 32'(rsp_c), q[0].c);
      void'(q.pop_front());
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 0);
      chk("rsp_id_idle", 32'(rsp_id), 0);
      chk("rsp_c_idle", 32'(rsp_c), 0);
    end
    g_obs = gnt;
    if (rsp_valid === 1'b1) begin last_c = int'(rsp_c); last_id = int'(rsp_id); end
    if (r) begin
      q.delete();
      ptr = 0;
    end else if (g >= 0) begin
      q.push_back('{cyc + L, g, ea + eb});
      ptr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  initial begin
    rst = 1'b1; req = '0; req_a = '0; req_b = '0;
    @(posedge clk);
    #1;
    cyc++;
    step(1, 4'b0000, '0, '0);
    last_c = -1; last_id = -1;
    step(0, 4'b0010, 16'h0030, 16'h0050);
    chk("single_gnt", 32'(g_obs), 32'h2);
    for (int i = 0; i < L; i++) step(0, 4'b0000, '0, '0);
    chk("single_rsp_c", last_c, 8);
    chk("single_rsp_id", last_id, 1);
    step(1, 4'b0000, '0, '0);
    for (int i = 0; i < 6; i++) begin
      step(0, 4'b1111, $urandom, $urandom);
      chk("rr_seq", 32'(g_obs), 1 << (i % 4));
    end
    step(0, 4'b1000, 16'h1234, 16'h4321);
    chk("wrap_g3", 32'(g_obs), 32'h8);
    step(0, 4'b1001, 16'h1234, 16'h4321);
    chk("wrap_g0", 32'(g_obs), 32'h1);
    step(0, 4'b1001, 16'h1234, 16'h4321);
    chk("wrap_g3b", 32'(g_obs), 32'h8);
    last_c = -1;
    step(0, 4'b0001, 16'h000f, 16'h000f);
    for (int i = 0; i < L; i++) step(0, 4'b0000, '0, '0);
    chk("overflow_c", last_c, 30);
    step(0, 4'b0100, 16'h0100, 16'h0100);
    step(1, 4'b0000, '0, '0);
    for (int i = 0; i < L + 1; i++) step(0, 4'b0000, '0, '0);
    step(0, 4'b1111, '0, '0);
    chk("post_rst_g0", 32'(g_obs), 32'h1);
    step(0, 4'b0010, '0, '0);
    for (int i = 0; i < 10; i++) step(0, 4'b0000, '0, '0);
    step(0, 4'b1111, '0, '0);
    chk("idle_ptr", 32'(g_obs), 32'h4);
    for (int i = 0; i < 400; i++) begin
      if (i % 50 < 10) step($urandom_range(0, 39) == 0, 4'(1 << $urandom_range(0, 3)), $urandom, $urandom);
      else step($urandom_range(0, 39) == 0, 4'($urandom), $urandom, $urandom);
    end
    for (int i = 0; i < L + 1; i++) step(0, 4'b0000, '0, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
